// File: rtl/gcd_engine_param.sv
// Iterative GCD engine with valid/ready handshakes, selectable subtractive Euclid
// or binary Stein iteration, and a saturating count of the cycles spent computing.
module gcd_engine_param #(
    parameter int WIDTH = 16,
    parameter int MODE  = 0,
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd,
    output logic [CNT_W-1:0] cycles
);

    localparam int K_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] x_step;
    logic [WIDTH-1:0] y_step;
    logic [K_W-1:0]   k;
    logic [K_W-1:0]   k_step;
    logic             calc_end;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign calc_end  = (x == '0) || (y == '0);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One reduction step; k counts common factors of two removed in Stein mode.
    always_comb begin
        x_step = x;
        y_step = y;
        k_step = k;
        if (MODE == 0) begin
            if (x > y) x_step = x - y;
            else       y_step = y - x;
        end else begin
            if (!x[0] && !y[0]) begin
                x_step = x >> 1;
                y_step = y >> 1;
                k_step = k + 1'b1;
            end else if (!x[0]) begin
                x_step = x >> 1;
            end else if (!y[0]) begin
                y_step = y >> 1;
            end else if (x >= y) begin
                x_step = x - y;
            end else begin
                y_step = y - x;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (calc_end)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            k      <= '0;
            gcd    <= '0;
            cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x      <= a;
                        y      <= b;
                        k      <= '0;
                        cycles <= '0;
                    end
                end
                CALC: begin
                    cycles <= sat_inc(cycles);
                    // Termination wins over stepping, so a zero operand finishes in one cycle.
                    if (calc_end) begin
                        gcd <= (x | y) << k;
                    end else begin
                        x <= x_step;
                        y <= y_step;
                        k <= k_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine_param.sv
// Scoreboard bench for gcd_engine_param: four instances covering both modes,
// a 32-bit build and a narrow saturating counter.
module tb_gcd_engine_param;

    typedef struct {
        int          id;
        logic [31:0] g;
        logic [31:0] c;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [4];
    logic        in_valid[4];
    logic        ordy    [4];
    logic        ir      [4];
    logic        ov      [4];
    logic [31:0] a_s     [4];
    logic [31:0] b_s     [4];
    logic [31:0] gcd_v   [4];
    logic [31:0] cyc_v   [4];

    logic [15:0] g0, g1, g3;
    logic [31:0] g2;
    logic [16:0] c0, c1, c2;
    logic [3:0]  c3;

    assign gcd_v[0] = {16'd0, g0};
    assign gcd_v[1] = {16'd0, g1};
    assign gcd_v[2] = g2;
    assign gcd_v[3] = {16'd0, g3};
    assign cyc_v[0] = {15'd0, c0};
    assign cyc_v[1] = {15'd0, c1};
    assign cyc_v[2] = {15'd0, c2};
    assign cyc_v[3] = {28'd0, c3};

    gcd_engine_param #(.WIDTH(16), .MODE(0), .CNT_W(17)) u_e16 (
        .clk(clk), .rst(rst_s[0]), .in_valid(in_valid[0]), .in_ready(ir[0]),
        .a(a_s[0][15:0]), .b(b_s[0][15:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .gcd(g0), .cycles(c0));

    gcd_engine_param #(.WIDTH(16), .MODE(1), .CNT_W(17)) u_s16 (
        .clk(clk), .rst(rst_s[1]), .in_valid(in_valid[1]), .in_ready(ir[1]),
        .a(a_s[1][15:0]), .b(b_s[1][15:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .gcd(g1), .cycles(c1));

    gcd_engine_param #(.WIDTH(32), .MODE(0), .CNT_W(17)) u_e32 (
        .clk(clk), .rst(rst_s[2]), .in_valid(in_valid[2]), .in_ready(ir[2]),
        .a(a_s[2]), .b(b_s[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .gcd(g2), .cycles(c2));

    gcd_engine_param #(.WIDTH(16), .MODE(0), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst_s[3]), .in_valid(in_valid[3]), .in_ready(ir[3]),
        .a(a_s[3][15:0]), .b(b_s[3][15:0]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .gcd(g3), .cycles(c3));

    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm, act, act, exp, exp);
        end
    endtask

    // Monitor: every completed output handshake must match the oldest expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ov[i] && ordy[i]) begin
                if (sbq.size() == 0 || sbq[0].id != i) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result dut%0d: got gcd=%0d cycles=%0d, expected none",
                             i, gcd_v[i], cyc_v[i]);
                end else begin
                    mon_e = sbq.pop_front();
                    check({mon_e.nm, ".gcd"}, gcd_v[i], mon_e.g);
                    check({mon_e.nm, ".cycles"}, cyc_v[i], mon_e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] g, input logic [31:0] c,
                         input bit expect_res, input string nm);
        int n = 0;
        while (!ir[i] && n < 200) begin
            tick();
            n++;
        end
        if (!ir[i]) begin
            tests++;
            fails++;
            $display("FAIL %s.accept_timeout: in_ready=%0b, expected 1", nm, ir[i]);
        end
        a_s[i]      = av;
        b_s[i]      = bv;
        in_valid[i] = 1'b1;
        if (expect_res) sbq.push_back('{i, g, c, nm});
        tick();
        in_valid[i] = 1'b0;
        a_s[i]      = 32'hDEAD_BEEF;
        b_s[i]      = 32'h0BAD_F00D;
    endtask

    task automatic drain(input int budget, input string nm);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s.result_timeout: %0d results outstanding, expected 0", nm, sbq.size());
            sbq.delete();
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_s[i]    = 1'b1;
            in_valid[i] = 1'b0;
            ordy[i]     = 1'b1;
            a_s[i]      = '0;
            b_s[i]      = '0;
        end
        repeat (3) tick();
        for (int i = 0; i < 4; i++) rst_s[i] = 1'b0;

        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset%0d.in_ready", i), {31'd0, ir[i]}, 32'd1);
            check($sformatf("reset%0d.out_valid", i), {31'd0, ov[i]}, 32'd0);
            check($sformatf("reset%0d.gcd", i), gcd_v[i], 32'd0);
            check($sformatf("reset%0d.cycles", i), cyc_v[i], 32'd0);
        end

        // Basic function in both modes.
        issue(0, 48, 18, 6, 6, 1'b1, "euclid_48_18");
        drain(100, "euclid_48_18");
        check("euclid_48_18.out_valid_one_cycle", {31'd0, ov[0]}, 32'd0);
        issue(1, 48, 18, 6, 8, 1'b1, "stein_48_18");
        drain(100, "stein_48_18");

        // Zero operands terminate on the first CALC cycle.
        for (int m = 0; m < 2; m++) begin
            issue(m, 0, 0, 0, 1, 1'b1, $sformatf("zero%0d_0_0", m));
            drain(50, "zero_0_0");
            issue(m, 0, 35, 35, 1, 1'b1, $sformatf("zero%0d_0_35", m));
            drain(50, "zero_0_35");
            issue(m, 35, 0, 35, 1, 1'b1, $sformatf("zero%0d_35_0", m));
            drain(50, "zero_35_0");
        end

        // Backpressure: result and count must hold while out_ready is low.
        ordy[1] = 1'b0;
        issue(1, 1071, 462, 21, 13, 1'b1, "stein_1071_462");
        begin
            int n = 0;
            while (!ov[1] && n < 100) begin
                tick();
                n++;
            end
        end
        check("bp.out_valid_seen", {31'd0, ov[1]}, 32'd1);
        for (int t = 0; t < 5; t++) begin
            check($sformatf("bp%0d.gcd", t), gcd_v[1], 32'd21);
            check($sformatf("bp%0d.cycles", t), cyc_v[1], 32'd13);
            check($sformatf("bp%0d.in_ready", t), {31'd0, ir[1]}, 32'd0);
            check($sformatf("bp%0d.out_valid", t), {31'd0, ov[1]}, 32'd1);
            tick();
        end
        ordy[1] = 1'b1;
        tick();
        check("bp_release.in_ready", {31'd0, ir[1]}, 32'd1);
        check("bp_release.out_valid", {31'd0, ov[1]}, 32'd0);
        check("bp_release.gcd_kept", gcd_v[1], 32'd21);
        check("bp_release.scoreboard_empty", sbq.size(), 32'd0);

        // Reset during CALC cycle 100 aborts with no result.
        issue(0, 65535, 1, 0, 0, 1'b0, "abort");
        repeat (99) tick();
        check("abort.cycles_before_reset", cyc_v[0], 32'd99);
        check("abort.busy", {31'd0, ir[0]}, 32'd0);
        rst_s[0] = 1'b1;
        tick();
        rst_s[0] = 1'b0;
        check("abort.in_ready", {31'd0, ir[0]}, 32'd1);
        check("abort.out_valid", {31'd0, ov[0]}, 32'd0);
        check("abort.gcd", gcd_v[0], 32'd0);
        check("abort.cycles", cyc_v[0], 32'd0);
        issue(0, 12, 8, 4, 4, 1'b1, "after_abort_12_8");
        drain(100, "after_abort_12_8");

        // Wide operands and counter saturation.
        issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b1, "w32_max_max");
        drain(100, "w32_max_max");
        issue(3, 100, 1, 1, 15, 1'b1, "sat_100_1");
        drain(300, "sat_100_1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
